// File: rtl/pipe_pkg.sv
// pipe_pkg: state encoding and occupancy helper shared by the skid stage.
package pipe_pkg;
    localparam int CNT_W = 2;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    function automatic logic [CNT_W-1:0] state_count(state_t s);
        return (s == TWO) ? 2'd2 : (s == ONE) ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+payload register; clear wins over load and parks BUBBLE_DATA.
module pipe_slot #(
    parameter int                DATA_W      = 64,
    parameter logic [DATA_W-1:0] RST_DATA    = '0,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= RST_DATA;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= BUBBLE_DATA;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end
    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer with registered in_ready/out_data and flush.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 64,
    parameter logic [DATA_W-1:0] RST_DATA    = '0,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  count
);
    state_t            r_state, w_state_nxt;
    logic              r_in_ready;
    logic [CNT_W-1:0]  r_count;
    logic              w_accept, w_emit, w_main_valid, w_skid_valid;
    logic              w_main_load, w_main_clear, w_skid_load, w_skid_clear;
    logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_d;
    always_comb begin
        w_accept    = in_valid & r_in_ready;
        w_emit      = w_main_valid & out_ready;
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   w_state_nxt = w_accept ? ONE : EMPTY;
            ONE:     w_state_nxt = (w_accept == w_emit) ? ONE : (w_accept ? TWO : EMPTY);
            TWO:     w_state_nxt = w_emit ? ONE : TWO;
            default: w_state_nxt = EMPTY;
        endcase
        if (flush) w_state_nxt = EMPTY;
        // main refills from skid when skid holds the older entry, else from the input
        w_main_load  = w_emit ? (w_accept | (r_state == TWO)) : (w_accept & (r_state == EMPTY));
        w_main_clear = flush | (w_emit & ~w_accept & (r_state == ONE));
        w_skid_load  = w_accept & ~w_emit & (r_state == ONE);
        w_skid_clear = flush | (w_emit & (r_state == TWO));
        w_main_d     = w_skid_valid ? w_skid_data : in_data;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != TWO);
            r_count    <= state_count(w_state_nxt);
        end
    end
    pipe_slot #(.DATA_W(DATA_W), .RST_DATA(RST_DATA), .BUBBLE_DATA(BUBBLE_DATA)) u_main (
        .clk(clk), .rst_n(rst_n), .i_load(w_main_load), .i_clear(w_main_clear),
        .i_data(w_main_d), .o_valid(w_main_valid), .o_data(w_main_data)
    );
    pipe_slot #(.DATA_W(DATA_W), .RST_DATA(RST_DATA), .BUBBLE_DATA(BUBBLE_DATA)) u_skid (
        .clk(clk), .rst_n(rst_n), .i_load(w_skid_load), .i_clear(w_skid_clear),
        .i_data(in_data), .o_valid(w_skid_valid), .o_data(w_skid_data)
    );
    assign in_ready  = r_in_ready;
    assign out_valid = w_main_valid;
    assign out_data  = w_main_data;
    assign count     = r_count;
endmodule
